// File: rtl/nios2_key_pkg.sv
// Shared definitions for the push-button controller: register map, bit positions
// and the per-key debounce state type.
package nios2_key_pkg;

  localparam logic [2:0] KEY_REG_DATA   = 3'd0;
  localparam logic [2:0] KEY_REG_MASK   = 3'd1;
  localparam logic [2:0] KEY_REG_EDGE   = 3'd2;
  localparam logic [2:0] KEY_REG_EVENT  = 3'd3;
  localparam logic [2:0] KEY_REG_STATUS = 3'd4;

  localparam int unsigned EVENT_VALID_BIT = 31;
  localparam int unsigned STATUS_OVF_BIT  = 8;

  typedef enum logic {
    DEB_IDLE,
    DEB_CHECK
  } deb_state_e;

endpackage

// File: rtl/nios2_key_debounce.sv
// One button: 2-flop synchroniser, debounce FSM and counter. Produces the accepted
// level and a one-cycle pulse when the accepted level falls (button pressed).
module nios2_key_debounce
  import nios2_key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1, sync2;
  deb_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             stable_nx, press_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      state  <= DEB_IDLE;
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      sync1  <= key_raw;
      sync2  <= sync1;
      state  <= state_nx;
      cnt    <= cnt_nx;
      stable <= stable_nx;
      press  <= press_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stable_nx = stable;
    press_nx  = 1'b0;
    case (state)
      DEB_IDLE: begin
        if (sync2 != stable) begin
          cnt_nx   = CNT_W'(1);
          state_nx = DEB_CHECK;
        end
      end
      DEB_CHECK: begin
        if (sync2 == stable) begin
          cnt_nx   = '0;
          state_nx = DEB_IDLE;
        end else if (cnt == CNT_LAST) begin
          stable_nx = sync2;
          press_nx  = ~sync2;
          cnt_nx    = '0;
          state_nx  = DEB_IDLE;
        end else if (cnt < CNT_LAST) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = DEB_IDLE;
    endcase
  end

endmodule

// File: rtl/nios2_key_ctrl.sv
// Avalon-MM push-button controller: debounced levels, sticky press flags, a press
// event FIFO and a maskable level interrupt for the Nios II.
module nios2_key_ctrl
  import nios2_key_pkg::*;
#(
  parameter int unsigned KEY_W      = 3,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] in_port,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [KEY_W-1:0] stable, press;
  logic [KEY_W-1:0] mask, edge_cap, w1c_edge;
  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic             ovf, ovf_set, ovf_clr;
  logic             rd_en, wr_en, empty, full, push, push_ok, pop;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    nios2_key_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .key_raw(in_port[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

  assign unused_wdata = &{1'b0, writedata};

  assign rd_en = chipselect & read;
  assign wr_en = chipselect & write;
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == PTR_W'(FIFO_DEPTH));
  assign push  = |press;
  assign pop   = rd_en && (address == KEY_REG_EVENT) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = wr_en && (address == KEY_REG_STATUS) && writedata[STATUS_OVF_BIT];
  assign w1c_edge = (wr_en && (address == KEY_REG_EDGE)) ? writedata[KEY_W-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      KEY_REG_DATA: rd_mux[KEY_W-1:0] = ~stable;
      KEY_REG_MASK: rd_mux[KEY_W-1:0] = mask;
      KEY_REG_EDGE: rd_mux[KEY_W-1:0] = edge_cap;
      KEY_REG_EVENT: begin
        if (!empty) begin
          rd_mux[EVENT_VALID_BIT] = 1'b1;
          rd_mux[KEY_W-1:0]       = mem[rd_ptr[AW-1:0]];
        end
      end
      KEY_REG_STATUS: begin
        rd_mux[7:0]            = 8'(count);
        rd_mux[STATUS_OVF_BIT] = ovf;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= press;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      mask     <= '0;
      edge_cap <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (rd_en) readdata <= rd_mux;
      irq      <= |(edge_cap & mask);
      if (wr_en && (address == KEY_REG_MASK)) mask <= writedata[KEY_W-1:0];
      edge_cap <= (edge_cap & ~w1c_edge) | press;
      ovf      <= (ovf & ~ovf_clr) | ovf_set;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule
